// File: rtl/la_wb_pkg.sv
// Shared constants and decode helpers for the logic-analyzer Wishbone slave.
// Offsets are byte offsets within the 256-byte block.
package la_wb_pkg;

  localparam logic [31:0] BASE_ADR_DEFAULT = 32'h2200_0000;

  localparam logic [7:0] LA_DATA_0 = 8'h00;
  localparam logic [7:0] LA_DATA_1 = 8'h04;
  localparam logic [7:0] LA_DATA_2 = 8'h08;
  localparam logic [7:0] LA_DATA_3 = 8'h0C;
  localparam logic [7:0] LA_ENA_0  = 8'h10;
  localparam logic [7:0] LA_ENA_1  = 8'h14;
  localparam logic [7:0] LA_ENA_2  = 8'h18;
  localparam logic [7:0] LA_ENA_3  = 8'h1C;

  localparam int NUM_REGS = 8;

  typedef enum logic [2:0] {
    REG_DATA_0, REG_DATA_1, REG_DATA_2, REG_DATA_3,
    REG_ENA_0,  REG_ENA_1,  REG_ENA_2,  REG_ENA_3
  } reg_idx_e;

  // Word-aligned offset in; returns whether it maps to a register and which one.
  function automatic logic off_decode(input logic [7:0] off, output reg_idx_e idx);
    logic hit;
    hit = 1'b1;
    idx = REG_DATA_0;
    case (off)
      LA_DATA_0: idx = REG_DATA_0;
      LA_DATA_1: idx = REG_DATA_1;
      LA_DATA_2: idx = REG_DATA_2;
      LA_DATA_3: idx = REG_DATA_3;
      LA_ENA_0:  idx = REG_ENA_0;
      LA_ENA_1:  idx = REG_ENA_1;
      LA_ENA_2:  idx = REG_ENA_2;
      LA_ENA_3:  idx = REG_ENA_3;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/la_wb_reg32.sv
// 32-bit register with per-byte write enables and synchronous active-high reset.
module la_wb_reg32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) q[8*b +: 8] <= d[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/la_wb.sv
// Wishbone slave exposing the 128-bit logic analyzer data and output-enable
// words as eight 32-bit registers; single-cycle registered acknowledge.
module la_wb
  import la_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = BASE_ADR_DEFAULT
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wb_stb_i,
  input  logic         wb_cyc_i,
  input  logic         wb_we_i,
  input  logic [3:0]   wb_sel_i,
  input  logic [31:0]  wb_dat_i,
  input  logic [31:0]  wb_adr_i,
  output logic         wb_ack_o,
  output logic [31:0]  wb_dat_o,
  output logic [127:0] la_data,
  output logic [127:0] la_oen
);

  logic        blk_sel;
  logic        access;
  logic        mapped;
  logic        wr_en;
  reg_idx_e    reg_idx;
  logic [7:0]  word_off;
  logic [31:0] rd_data;
  logic [31:0] regs [NUM_REGS];
  logic        unused_adr_lsb;

  // Byte lanes within a word are not part of the decode.
  assign word_off       = {wb_adr_i[7:2], 2'b00};
  assign unused_adr_lsb = ^wb_adr_i[1:0];

  assign blk_sel = wb_stb_i & wb_cyc_i & (wb_adr_i[31:8] == BASE_ADR[31:8]);
  assign access  = blk_sel & ~wb_ack_o;

  always_comb begin
    reg_idx = REG_DATA_0;
    mapped  = off_decode(word_off, reg_idx);
  end

  assign wr_en   = access & wb_we_i & mapped;
  assign rd_data = mapped ? regs[reg_idx] : '0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    la_wb_reg32 u_reg (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .we  (wr_en && (reg_idx == reg_idx_e'(g))),
      .sel (wb_sel_i),
      .d   (wb_dat_i),
      .q   (regs[g])
    );
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= access;
      if (access & ~wb_we_i) wb_dat_o <= rd_data;
    end
  end

  assign la_data = {regs[REG_DATA_3], regs[REG_DATA_2], regs[REG_DATA_1], regs[REG_DATA_0]};
  assign la_oen  = {regs[REG_ENA_3],  regs[REG_ENA_2],  regs[REG_ENA_1],  regs[REG_ENA_0]};

endmodule

// File: tb/tb_la_wb.sv
// Scoreboard bench for la_wb: accesses push expected responses, a monitor
// pops and compares on every acknowledge.
module tb_la_wb;

  localparam logic [31:0] BASE = 32'h2200_0000;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b0;
  logic         wb_stb_i = 1'b0;
  logic         wb_cyc_i = 1'b0;
  logic         wb_we_i  = 1'b0;
  logic [3:0]   wb_sel_i = 4'h0;
  logic [31:0]  wb_dat_i = 32'h0;
  logic [31:0]  wb_adr_i = 32'h0;
  logic         wb_ack_o;
  logic [31:0]  wb_dat_o;
  logic [127:0] la_data;
  logic [127:0] la_oen;

  la_wb dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_adr_i (wb_adr_i),
    .wb_ack_o (wb_ack_o),
    .wb_dat_o (wb_dat_o),
    .la_data  (la_data),
    .la_oen   (la_oen)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    bit          rd;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mdl [8];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Register index for an address inside the block, or -1 for an unmapped offset.
  function automatic int midx(input logic [31:0] a);
    int off;
    off = int'(a[7:0]) / 4;
    return (off < 8) ? off : -1;
  endfunction

  function automatic logic [127:0] mdl_data();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  function automatic logic [127:0] mdl_oen();
    return {mdl[7], mdl[6], mdl[5], mdl[4]};
  endfunction

  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && wb_ack_o === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got ack at %0t, expected none", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (e.rd) check(e.name, wb_dat_o, e.exp);
      end
    end
  end

  task automatic wb_access(input logic [31:0] adr, input bit we, input logic [31:0] dat,
                           input logic [3:0] sel, input string nm);
    exp_t e;
    int   i;
    int   n;
    i      = midx(adr);
    e.rd   = !we;
    e.exp  = (i >= 0) ? mdl[i] : 32'h0;
    e.name = nm;
    sbq.push_back(e);
    @(posedge wb_clk_i); #1;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    n = 0;
    do begin
      @(posedge wb_clk_i); #1;
      n++;
    end while (wb_ack_o !== 1'b1 && n < 4);
    check({"ack_latency_", nm}, n, 1);
    if (we && i >= 0 && wb_ack_o === 1'b1) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) mdl[i][8*b +: 8] = dat[8*b +: 8];
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  initial begin
    logic [31:0] vals [4];
    logic [31:0] adr;
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;

    // reset
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    check("rst_ack", wb_ack_o, 0);
    check("rst_dat_o", wb_dat_o, 0);
    check("rst_la_data", la_data, 0);
    check("rst_la_oen", la_oen, 0);
    wb_access(BASE | 32'h00, 0, 32'h0, 4'hF, "rst_read0");

    // data registers
    vals[0] = 32'hDEADBEEF; vals[1] = 32'h12345678;
    vals[2] = 32'hA5A5A5A5; vals[3] = 32'h0F0F0F0F;
    for (int i = 0; i < 4; i++)
      wb_access(BASE | (32'(i) * 4), 1, vals[i], 4'hF, $sformatf("wr_data%0d", i));
    for (int i = 0; i < 4; i++)
      wb_access(BASE | (32'(i) * 4), 0, 32'h0, 4'hF, $sformatf("rd_data%0d", i));
    check("la_data_fixed", la_data, 128'h0F0F0F0F_A5A5A5A5_12345678_DEADBEEF);

    // enable registers
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      wb_access(BASE | (32'h10 + 32'(i) * 4), 1, vals[i], 4'hF, $sformatf("wr_ena%0d", i));
    end
    for (int i = 0; i < 4; i++)
      wb_access(BASE | (32'h10 + 32'(i) * 4), 0, 32'h0, 4'hF, $sformatf("rd_ena%0d", i));
    check("la_oen_concat", la_oen, {vals[3], vals[2], vals[1], vals[0]});

    // byte enables
    wb_access(BASE | 32'h04, 1, 32'hFFFFFFFF, 4'hF, "be_fill");
    wb_access(BASE | 32'h04, 1, 32'h00000000, 4'b0101, "be_clear");
    wb_access(BASE | 32'h04, 0, 32'h0, 4'hF, "be_read");
    check("be_la_word1", la_data[63:32], 32'hFF00FF00);

    // held strobe: ack alternates, one read completes per ack
    begin
      exp_t e;
      e.rd = 1'b1; e.exp = mdl[2]; e.name = "held_rd";
      sbq.push_back(e);
      sbq.push_back(e);
      @(posedge wb_clk_i); #1;
      wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = BASE | 32'h08;
      for (int k = 0; k < 4; k++) begin
        @(posedge wb_clk_i); #1;
        check($sformatf("held_ack_c%0d", k), wb_ack_o, (k % 2 == 0) ? 1 : 0);
      end
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    end

    // outside the block: never acknowledged, nothing written
    begin
      int acks;
      acks = 0;
      @(posedge wb_clk_i); #1;
      wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1;
      wb_adr_i = 32'h3000_0000; wb_dat_i = 32'hCAFEF00D; wb_sel_i = 4'hF;
      for (int k = 0; k < 10; k++) begin
        @(posedge wb_clk_i); #1;
        if (wb_ack_o === 1'b1) acks++;
      end
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
      check("foreign_no_ack", acks, 0);
      check("foreign_la_data", la_data, mdl_data());
    end

    // unmapped offset inside the block
    wb_access(BASE | 32'h40, 1, 32'h55, 4'hF, "unmap_wr");
    check("unmap_la_data", la_data, mdl_data());
    check("unmap_la_oen", la_oen, mdl_oen());
    wb_access(BASE | 32'h40, 0, 32'h0, 4'hF, "unmap_rd");

    // random traffic over mapped and unmapped offsets, any byte lane address
    for (int t = 0; t < 60; t++) begin
      adr = BASE | (32'($urandom_range(0, 15)) * 4) | 32'($urandom_range(0, 3));
      wb_access(adr, bit'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                $sformatf("rand%0d_%h", t, adr[7:0]));
    end
    check("rand_la_data", la_data, mdl_data());
    check("rand_la_oen", la_oen, mdl_oen());

    // reset after traffic clears everything
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    check("rst2_la_data", la_data, 0);
    check("rst2_la_oen", la_oen, 0);
    wb_access(BASE | 32'h1C, 0, 32'h0, 4'hF, "rst2_rd_ena3");

    repeat (3) @(posedge wb_clk_i);
    #1;
    check("scoreboard_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
